// File: rtl/uart_fifo_tester.sv
// UART exerciser: FIFO-buffered TX/RX around small serial cores, runtime frame mode,
// sticky error flags and a saturating frame-error counter for board bring-up.

module uart_core_tx #(
    parameter int CLK_FREQ       = 100,
    parameter int BAUD_DIV_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [7:0]                data,
    input  logic [BAUD_DIV_WIDTH-1:0] div,
    input  logic [1:0]                data_type,
    input  logic [1:0]                stop_type,
    input  logic                      check_en,
    input  logic [1:0]                check_type,
    output logic                      tx,
    output logic                      busy,
    output logic                      ack
);
    // A zero divisor falls back to CLK_FREQ clocks per bit.
    localparam logic [15:0] DEF_LEN = 16'(CLK_FREQ);

    logic [15:0] bit_len, cnt;
    logic [11:0] frame, sh;
    logic [3:0]  n_data, n_bits, left;
    logic [7:0]  mask;
    logic        par;

    assign bit_len = (div == '0) ? DEF_LEN : 16'(div);
    assign n_data  = 4'd8 - {2'b00, data_type};
    assign n_bits  = 4'd1 + n_data + {3'b000, check_en} + ((stop_type == 2'd0) ? 4'd1 : 4'd2);
    assign mask    = 8'hFF >> data_type;
    assign par     = check_type[1] ? check_type[0] : (^(data & mask) ^ check_type[0]);
    assign ack     = busy && (cnt == 16'd0) && (left == 4'd1);
    assign tx      = busy ? sh[0] : 1'b1;

    // Start bit in [0], data LSB first, optional parity; the all-ones fill forms the stop bits.
    always_comb begin
        frame    = '1;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++)
            if (i < int'(n_data)) frame[i+1] = data[i];
        if (check_en) frame[n_data + 4'd1] = par;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            sh   <= '1;
            cnt  <= '0;
            left <= '0;
        end else if (!busy) begin
            if (en) begin
                busy <= 1'b1;
                sh   <= frame;
                left <= n_bits;
                cnt  <= bit_len - 16'd1;
            end
        end else if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
        end else begin
            cnt  <= bit_len - 16'd1;
            sh   <= {1'b1, sh[11:1]};
            left <= left - 4'd1;
            if (left == 4'd1) busy <= 1'b0;
        end
    end
endmodule

module uart_core_rx #(
    parameter int CLK_FREQ       = 100,
    parameter int BAUD_DIV_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      rx,
    input  logic [BAUD_DIV_WIDTH-1:0] div,
    input  logic [1:0]                data_type,
    input  logic                      check_en,
    input  logic [1:0]                check_type,
    output logic                      busy,
    output logic                      ack,
    output logic                      err,
    output logic [7:0]                data
);
    localparam logic [15:0] DEF_LEN = 16'(CLK_FREQ);

    logic [15:0] bit_len, cnt;
    logic [3:0]  idx, n_data;
    logic [2:0]  bit_pos;
    logic        r1, r2, r3, par, perr;

    assign bit_len = (div == '0) ? DEF_LEN : 16'(div);
    assign n_data  = 4'd8 - {2'b00, data_type};
    assign bit_pos = 3'(idx - 4'd1);

    // A start needs a high-to-low edge, so a low line after a bad stop bit is not a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            {r3, r2, r1} <= 3'b111;
            busy <= 1'b0;
            ack  <= 1'b0;
            err  <= 1'b0;
            data <= '0;
            cnt  <= '0;
            idx  <= '0;
            par  <= 1'b0;
            perr <= 1'b0;
        end else begin
            {r3, r2, r1} <= {r2, r1, rx};
            ack <= 1'b0;
            err <= 1'b0;
            if (!busy) begin
                if (en && r3 && !r2) begin
                    busy <= 1'b1;
                    cnt  <= bit_len >> 1;
                    idx  <= '0;
                    data <= '0;
                    par  <= 1'b0;
                    perr <= 1'b0;
                end
            end else if (cnt != 16'd0) begin
                cnt <= cnt - 16'd1;
            end else begin
                cnt <= bit_len - 16'd1;
                idx <= idx + 4'd1;
                if (idx == 4'd0) begin
                    if (r2) busy <= 1'b0;
                end else if (idx <= n_data) begin
                    data[bit_pos] <= r2;
                    par <= par ^ r2;
                end else if (check_en && (idx == n_data + 4'd1)) begin
                    perr <= r2 != (check_type[1] ? check_type[0] : (par ^ check_type[0]));
                end else begin
                    busy <= 1'b0;
                    ack  <= r2 && !perr;
                    err  <= !r2 || perr;
                end
            end
        end
    end
endmodule

module uart_fifo_tester #(
    parameter int CLK_FREQ       = 100,
    parameter int BAUD_DIV_WIDTH = 8,
    parameter int FIFO_AW        = 4,
    parameter int CAPTURE_BYTES  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                uart_mode,
    input  logic                       wr,
    input  logic [7:0]                 din,
    input  logic                       rd,
    output logic [7:0]                 dout,
    output logic [8*CAPTURE_BYTES-1:0] capture,
    input  logic                       clr,
    output logic [15:0]                status,
    input  logic                       uart_rx,
    output logic                       uart_tx
);
    localparam int CW = 8 * CAPTURE_BYTES;
    localparam logic [FIFO_AW:0]   FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, SEND} tx_state_t;
    tx_state_t state, state_nx;

    logic [15:0]               mode_reg;
    logic [BAUD_DIV_WIDTH-1:0] baud_div;
    logic                      unused_mode;
    logic [7:0]                tx_mem [0:(1<<FIFO_AW)-1];
    logic [7:0]                rx_mem [0:(1<<FIFO_AW)-1];
    logic [FIFO_AW-1:0]        tx_wp, tx_rp, rx_wp, rx_rp;
    logic [FIFO_AW:0]          tx_cnt, rx_cnt;
    logic [7:0]                tx_data, rx_data;
    logic tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;
    logic core_busy, tx_en, tx_ack, tx_busy, rx_busy, rx_ack, rx_err;
    logic tx_ovf, rx_ovf, rx_udf, rx_err_flag;
    logic [3:0] err_cnt;

    assign baud_div    = mode_reg[8 +: BAUD_DIV_WIDTH];
    assign unused_mode = mode_reg[0];
    assign tx_full     = tx_cnt == FULL_CNT;
    assign tx_empty    = tx_cnt == '0;
    assign rx_full     = rx_cnt == FULL_CNT;
    assign rx_empty    = rx_cnt == '0;
    assign tx_push     = wr && !tx_full;
    assign rx_push     = rx_ack && !rx_full;
    assign rx_pop      = rd && !rx_empty;
    assign tx_busy     = core_busy || (state == SEND);
    assign dout        = rx_empty ? 8'h00 : rx_mem[rx_rp];
    assign status      = {tx_busy, rx_busy, tx_full, tx_empty, rx_full, rx_empty,
                          tx_ovf, rx_ovf, rx_udf, rx_err_flag, 2'b00, err_cnt};

    uart_core_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_DIV_WIDTH(BAUD_DIV_WIDTH)) u_tx (
        .clk(clk), .rst(rst), .en(tx_en), .data(tx_data), .div(baud_div),
        .data_type(mode_reg[7:6]), .stop_type(mode_reg[5:4]), .check_en(mode_reg[3]),
        .check_type(mode_reg[2:1]), .tx(uart_tx), .busy(core_busy), .ack(tx_ack));

    uart_core_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_DIV_WIDTH(BAUD_DIV_WIDTH)) u_rx (
        .clk(clk), .rst(rst), .en(1'b1), .rx(uart_rx), .div(baud_div),
        .data_type(mode_reg[7:6]), .check_en(mode_reg[3]), .check_type(mode_reg[2:1]),
        .busy(rx_busy), .ack(rx_ack), .err(rx_err), .data(rx_data));

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (!tx_empty && !core_busy) state_nx = SEND;
            SEND: if (tx_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        tx_pop = (state == IDLE) && !tx_empty && !core_busy;
        tx_en  = (state == SEND);
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= din;
        if (rx_push) rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {tx_wp, tx_rp, rx_wp, rx_rp} <= '0;
            tx_cnt  <= '0;
            rx_cnt  <= '0;
            tx_data <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop) begin
                tx_rp   <= tx_rp + PTR_ONE;
                tx_data <= tx_mem[tx_rp];
            end
            if (tx_push && !tx_pop) tx_cnt <= tx_cnt + CNT_ONE;
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - CNT_ONE;
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop) rx_rp <= rx_rp + PTR_ONE;
            if (rx_push && !rx_pop) rx_cnt <= rx_cnt + CNT_ONE;
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - CNT_ONE;
        end
    end

    // Mode only follows the input while both directions are quiet.
    always_ff @(posedge clk) begin
        if (rst || ((state == IDLE) && !core_busy && !rx_busy)) mode_reg <= uart_mode;
    end

    // Flags: a set event in the same cycle as clr wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            {tx_ovf, rx_ovf, rx_udf, rx_err_flag} <= '0;
            err_cnt <= '0;
            capture <= '0;
        end else begin
            tx_ovf      <= (wr && tx_full) || (tx_ovf && !clr);
            rx_ovf      <= (rx_ack && rx_full) || (rx_ovf && !clr);
            rx_udf      <= (rd && rx_empty) || (rx_udf && !clr);
            rx_err_flag <= rx_err || (rx_err_flag && !clr);
            if (rx_err) err_cnt <= (err_cnt == 4'hF) ? err_cnt : err_cnt + 4'd1;
            else if (clr) err_cnt <= '0;
            if (rx_ack || rx_err) capture <= {capture[CW-9:0], rx_data};
        end
    end
endmodule

// File: tb/tb_uart_fifo_tester.sv
// Directed bench for uart_fifo_tester: loopback and hand-driven RX frames, with a
// queue-based monitor that drains the RX FIFO and compares each byte.

module tb_uart_fifo_tester;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] uart_mode;
    logic        wr, rd, clr;
    logic [7:0]  din, dout;
    logic [31:0] capture;
    logic [15:0] status;
    logic        uart_rx, uart_tx;
    logic        loop_en, drv_rx, mon_en, mon_rd, stim_rd;
    logic [7:0]  exp_q[$];
    int          total = 0;
    int          bad = 0;

    assign uart_rx = loop_en ? uart_tx : drv_rx;
    assign rd      = mon_rd | stim_rd;

    uart_fifo_tester #(.CLK_FREQ(100), .BAUD_DIV_WIDTH(8), .FIFO_AW(4), .CAPTURE_BYTES(4)) dut (
        .clk(clk), .rst(rst), .uart_mode(uart_mode), .wr(wr), .din(din), .rd(rd),
        .dout(dout), .capture(capture), .clr(clr), .status(status),
        .uart_rx(uart_rx), .uart_tx(uart_tx));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr  = 1'b1;
        din = b;
        tick();
        wr  = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Drives one 8N1 frame at 8 clocks per bit onto uart_rx.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drv_rx = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 8; i++) begin
            drv_rx = b[i];
            repeat (8) tick();
        end
        drv_rx = stop_bit;
        repeat (8) tick();
        drv_rx = 1'b1;
        repeat (24) tick();
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int q = 0;
        int n = 0;
        while (q < 4 && n < budget) begin
            tick();
            n++;
            if (!status[15] && !status[14] && status[12]) q++;
            else q = 0;
        end
        check(name, (q >= 4) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || !status[10]) && n < budget) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: pops the RX FIFO whenever it holds data and scores dout against exp_q.
    always @(negedge clk) begin
        if (mon_rd) begin
            mon_rd = 1'b0;
        end else if (mon_en && !rst && !status[10]) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rx_unexpected: got %0h want none", dout);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    bad++;
                    $display("FAIL rx_data: got %0h want %0h", dout, e);
                end
            end
            mon_rd = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; wr = 1'b0; din = '0; stim_rd = 1'b0; clr = 1'b0; mon_rd = 1'b0;
        uart_mode = 16'h8101; loop_en = 1'b1; drv_rx = 1'b1; mon_en = 1'b0;
        repeat (3) tick();
        check("reset_status", status, 16'h1400);
        check("reset_tx", uart_tx, 1'b1);
        check("reset_dout", dout, 8'h00);
        check("reset_capture", capture, 32'h0);
        rst = 1'b0;
        tick();

        // Loopback at divisor 0x81, FIFO left full until inspected.
        push(8'hA5); exp_q.push_back(8'hA5);
        push(8'h3C); exp_q.push_back(8'h3C);
        wait_quiet(4000, "lb_quiet");
        check("lb_tx_empty", status[12], 1'b1);
        check("lb_rx_nonempty", status[10], 1'b0);
        check("lb_flags", status[9:6], 4'h0);
        check("lb_capture", capture[15:0], 16'hA53C);
        mon_en = 1'b1;
        wait_drain(100, "lb_drain");

        // 7 data bits with even parity: 0xC3 arrives as 0x43.
        uart_mode = 16'h0849;
        repeat (3) tick();
        push(8'hC3); exp_q.push_back(8'h43);
        wait_quiet(500, "par_quiet");
        wait_drain(100, "par_drain");
        check("par_capture", capture[7:0], 8'h43);
        check("par_no_err", status[6], 1'b0);

        // TX overflow: core busy with a priming byte while 17 bytes are pushed.
        uart_mode = 16'h0801;
        repeat (3) tick();
        push(8'hEE); exp_q.push_back(8'hEE);
        w = 0;
        while (!status[15] && w < 10) begin tick(); w++; end
        check("ovf_busy_wait", status[15], 1'b1);
        for (int i = 0; i < 17; i++) begin
            push(8'(i));
            if (i < 16) exp_q.push_back(8'(i));
        end
        check("ovf_full", status[13], 1'b1);
        check("ovf_flag", status[9], 1'b1);
        wait_quiet(3000, "ovf_quiet");
        wait_drain(100, "ovf_drain");
        check("ovf_no_rx_ovf", status[8], 1'b0);
        pulse_clr();
        check("ovf_cleared", status[9:6], 4'h0);

        // Bad stop bits: error counter saturates, nothing enters the RX FIFO.
        loop_en = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            send_frame(8'(k), 1'b0);
            if (k == 14) check("err_cnt_14", status[3:0], 4'd14);
        end
        check("err_flag", status[6], 1'b1);
        check("err_cnt_sat", status[3:0], 4'hF);
        check("err_rx_empty", status[10], 1'b1);
        check("err_capture", capture, 32'h0F101112);
        pulse_clr();
        check("err_clr", {status[6], status[3:0]}, 5'h0);

        // Underflow, then clr racing a second underflow.
        stim_rd = 1'b1; tick(); stim_rd = 1'b0;
        check("udf_set", status[7], 1'b1);
        check("udf_dout", dout, 8'h00);
        clr = 1'b1; stim_rd = 1'b1; tick(); clr = 1'b0; stim_rd = 1'b0;
        check("udf_set_wins", status[7], 1'b1);
        pulse_clr();
        check("udf_clr", status[7], 1'b0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_drain(100, "udf_ptr_drain");

        // Mode change mid-frame: start-bit widths show old then new divisor.
        push(8'h55);
        push(8'h55);
        w = 0;
        while (uart_tx && w < 50) begin tick(); w++; end
        uart_mode = 16'h4101;
        w = 0;
        while (!uart_tx && w < 300) begin w++; tick(); end
        check("mode_old_width", w, 8);
        w = 0;
        while (status[15] && w < 200) begin tick(); w++; end
        w = 0;
        while (uart_tx && w < 50) begin tick(); w++; end
        w = 0;
        while (!uart_tx && w < 300) begin w++; tick(); end
        check("mode_new_width", w, 65);
        uart_mode = 16'h0801;
        wait_quiet(1500, "mode_quiet");

        // Reset mid-frame with bytes still queued.
        push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
        repeat (20) tick();
        check("rst_pre_queued", status[12], 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_tx_high", uart_tx, 1'b1);
        check("rst_status", status, 16'h1400);
        check("rst_capture", capture, 32'h0);
        repeat (100) tick();
        check("rst_stays_idle", {uart_tx, status[15]}, 2'b10);

        check("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_fifo_tester.md
Name: uart_fifo_tester

Overview:
- Parametrised UART exerciser: buffered TX and RX around uart_core_tx / uart_core_rx, with a runtime-programmable frame mode.
- Adds per-direction FIFOs, a TX launch FSM, a configurable RX capture window, sticky error flags with clear, and a saturating frame-error counter.
- Sits between the board test logic (switches/LEDs/bus strobes) and the UART pins; used for loopback and host-link bring-up.

Parameters:
- CLK_FREQ, 100, clk frequency in MHz, passed to both cores.
- BAUD_DIV_WIDTH, 8, baud divisor field width, passed to both cores.
- FIFO_AW, 4, log2 depth of each FIFO (depth 16).
- CAPTURE_BYTES, 4, number of bytes in the RX capture shift window.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- uart_mode  in  16  [15:8] baud_div, [7:6] data_type, [5:4] stop_type, [3] check_en, [2:1] check_type
- wr  in  1  one-cycle push strobe into TX FIFO
- din  in  8  TX byte
- rd  in  1  one-cycle pop strobe from RX FIFO
- dout  out  8  RX FIFO head (first-word-fall-through)
- capture  out  8*CAPTURE_BYTES  last received bytes, newest in [7:0]
- clr  in  1  clear sticky flags and error counter
- status  out  16  see Behaviour
- uart_rx  in  1  serial in
- uart_tx  out  1  serial out

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. Reset empties both FIFOs, puts the FSM in IDLE, loads mode_reg with uart_mode, and zeroes capture, sticky flags, err_cnt and dout. uart_tx idles high.
- mode_reg:
  - Loads uart_mode on any cycle where FSM=IDLE, tx_busy=0 and rx_busy=0.
  - Otherwise it holds, so mode changes never corrupt an in-flight frame.
  - Both cores take their mode fields from mode_reg.
- TX FIFO:
  - wr with count<depth writes din; write pointer wraps modulo depth.
  - wr with count==depth drops the byte and sets tx_ovf.
  - Full is judged on the start-of-cycle count; a same-cycle pop does not rescue the push.
- TX FSM:
  - IDLE: when the FIFO is non-empty and tx_busy=0, pop the head into tx_data and go to SEND.
  - SEND: hold core en=1 with tx_data until the tx_ack pulse, then drop en and return to IDLE.
  - Back-to-back bytes have a minimum gap of one IDLE cycle after ack.
- RX path: core en tied high.
  - rx_ack with RX FIFO not full: push the data. If full: drop it and set rx_ovf.
  - rx_err: push nothing, set rx_err flag, err_cnt += 1 saturating at 15.
  - capture shifts left by 8 and inserts the core data on rx_ack or rx_err.
- RX read:
  - dout always shows the RX FIFO head.
  - rd when non-empty advances the read pointer; dout shows the next entry in the following cycle.
  - rd when empty is ignored and sets rx_udf.
  - A simultaneous rx push and rd on an empty FIFO: the rd is an underflow and the push succeeds.
- Sticky flags (tx_ovf, rx_ovf, rx_udf, rx_err) and err_cnt clear on clr. If a set event and clr occur in the same cycle, the set wins.
- status bits:
  - [15] tx_busy (core busy or FSM=SEND)
  - [14] rx_busy
  - [13] tx_full, [12] tx_empty, [11] rx_full, [10] rx_empty
  - [9] tx_ovf, [8] rx_ovf, [7] rx_udf, [6] rx_err
  - [5:4] 0
  - [3:0] err_cnt
  - All registered except the full/empty bits, which derive from registered counts.

Test Plan:
- Loopback (uart_tx tied to uart_rx), mode 16'h8101, push 8'hA5 then 8'h3C → RX FIFO holds A5 then 3C; capture[15:0]=16'hA53C; status[12]=1 and [10]=0 after both frames; no sticky flags set.
- Push 17 bytes 8'h00..8'h10 in consecutive cycles with the FSM stalled by a busy core → byte 8'h10 is dropped and tx_ovf=1; all 16 others are transmitted in order.
- Drive uart_rx with a frame having a bad stop bit, 18 times → rx_err=1, err_cnt=15 (saturated); RX FIFO stays empty; capture still shifts.
- rd pulse with the RX FIFO empty → rx_udf=1, pointers unchanged. Then clr in the same cycle as a new rd on empty → rx_udf remains 1.
- Change uart_mode to 16'h4101 while a frame is in flight → current frame completes at the old divisor; the next frame uses divisor 8'h41.
- Assert rst mid-frame with 3 bytes queued → FIFOs empty, uart_tx high the next cycle, status=16'h1400 (tx_empty and rx_empty set, all else zero).
